regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, enabling write-to-read forwarding.
REQ-005 SHALL have parameter ZERO_REG, default 1, making entry 0 hardwired to zero.
REQ-006 SHALL have port clk  in  1  clock, rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port rd_en  in  NRD  per-port read enable.
REQ-009 SHALL have port rd_addr  in  NRD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-010 SHALL have port rd_data  out  NRD*DATA_W  packed registered read data.
REQ-011 SHALL have port rd_busy  out  NRD  registered pending-write flag per read port.
REQ-012 SHALL have ports wa_en/wa_addr/wa_data  in  1/ADDR_W/DATA_W  write port A (ALU writeback).
REQ-013 SHALL have ports wb_en/wb_addr/wb_data  in  1/ADDR_W/DATA_W  write port B (memory writeback).
REQ-014 SHALL have ports busy_set/busy_addr  in  1/ADDR_W  mark entry as awaiting writeback.
REQ-015 SHALL have ports dbg_addr  in  ADDR_W, and dbg_data  out  DATA_W, for combinational debug read.

Function
REQ-016 SHALL register rd_data[k] on the clk edge where rd_en[k]=1, giving 1-cycle latency; it SHALL hold when rd_en[k]=0.
REQ-017 SHALL, with BYPASS=1, return the data written on the same edge when the read address matches an enabled write address; with BYPASS=0 it SHALL return the pre-edge content.
REQ-018 SHALL, when wa and wb target the same address on the same edge, store wb_data (port B wins) and forward wb_data.
REQ-019 SHALL, with ZERO_REG=1, ignore writes to address 0, never set busy for address 0, and return 0 and busy=0 for reads of address 0.
REQ-020 SHALL keep one busy bit per entry: set on busy_set, cleared on any enabled write to that address.
REQ-021 SHALL, on simultaneous busy_set and write to the same address, leave the bit set (set wins).
REQ-022 SHALL register rd_busy[k] with rd_data[k] under rd_en[k], equal to the entry's busy bit after that edge's updates.
REQ-023 SHALL drive dbg_data combinationally from stored content, without bypass (0 for entry 0 when ZERO_REG=1).
REQ-024 SHALL never assert rd_busy[k] and forward valid data for the same address on the same edge unless busy_set also targeted that address.

Reset
REQ-025 SHALL, on rst=1, clear all entries, all busy bits, rd_data and rd_busy to 0 immediately.
REQ-026 SHALL ignore all reads, writes and busy_set while rst=1; first effective edge is the first rising clk edge after rst deasserts.

Structure
REQ-027 SHALL take the DATA_W/ADDR_W defaults and the zero-register index from shared package cpu_pkg.
REQ-028 SHALL implement the per-port read/bypass/busy logic as one sub-module rf_read_port, instantiated NRD times in a generate loop.

Verification
REQ-029 SHALL cover: write A r5=0x12345678, next cycle read r5 on port 0 -> rd_data0=0x12345678 one cycle later.
REQ-030 SHALL cover: same-edge write r7=0xDEADBEEF and read r7 -> BYPASS=1 gives 0xDEADBEEF, BYPASS=0 gives old value 0.
REQ-031 SHALL cover: wa and wb both write r3 (0x1, 0x2) on one edge -> r3=0x2 and dbg_data(r3)=0x2.
REQ-032 SHALL cover: write r0=0xFFFFFFFF and busy_set r0 -> read r0 returns 0 and busy=0.
REQ-033 SHALL cover: busy_set r9, read r9 -> busy=1; wb writes r9 -> busy=0; same-edge busy_set and write to r9 -> busy=1.
REQ-034 SHALL cover: rst asserted mid-write burst -> all outputs 0 asynchronously and writes on edges during rst lost.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants for the register file slice.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ZERO_IDX   = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write, busy-tracking and debug signals of the multi-port register file.
interface regfile_mp_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NRD    = 2
);

    logic [NRD-1:0]        rd_en;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;

    logic                  wa_en;
    logic [ADDR_W-1:0]     wa_addr;
    logic [DATA_W-1:0]     wa_data;
    logic                  wb_en;
    logic [ADDR_W-1:0]     wb_addr;
    logic [DATA_W-1:0]     wb_data;

    logic                  busy_set;
    logic [ADDR_W-1:0]     busy_addr;

    logic [ADDR_W-1:0]     dbg_addr;
    logic [DATA_W-1:0]     dbg_data;

    modport master (
        output rd_en, rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               busy_set, busy_addr, dbg_addr,
        input  rd_data, rd_busy, dbg_data
    );

    modport slave (
        input  rd_en, rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               busy_set, busy_addr, dbg_addr,
        output rd_data, rd_busy, dbg_data
    );

endinterface

// File: rtl/rf_read_port.sv
// One registered read port: picks stored or same-edge write data and tracks the busy bit.
module rf_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              stored_busy,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              wa_hit, wb_hit, set_hit, hardwired;

    always_comb begin
        wa_hit    = wa_en && (wa_addr == rd_addr);
        wb_hit    = wb_en && (wb_addr == rd_addr);
        set_hit   = busy_set && (busy_addr == rd_addr);
        hardwired = ZERO_REG && (rd_addr == ADDR_W'(ZERO_IDX));
        data_d    = data_q;
        busy_d    = busy_q;
        if (rd_en) begin
            data_d = stored_data;
            busy_d = stored_busy && !(wa_hit || wb_hit);
            // Port B is the winner on a same-address collision, so it is checked first.
            if (BYPASS && wb_hit) begin
                data_d = wb_data;
            end else if (BYPASS && wa_hit) begin
                data_d = wa_data;
            end
            if (set_hit) begin
                busy_d = 1'b1;
            end
            if (hardwired) begin
                data_d = '0;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign rd_data = data_q;
    assign rd_busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (B wins), NRD registered read ports,
// per-entry writeback-pending bits and a combinational debug read.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NRD      = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    function automatic logic is_hardwired(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == ADDR_W'(ZERO_IDX));
    endfunction

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (bus.wa_en && !is_hardwired(bus.wa_addr)) begin
            mem_d[bus.wa_addr]  = bus.wa_data;
            busy_d[bus.wa_addr] = 1'b0;
        end
        if (bus.wb_en && !is_hardwired(bus.wb_addr)) begin
            mem_d[bus.wb_addr]  = bus.wb_data;
            busy_d[bus.wb_addr] = 1'b0;
        end
        // A new pending writeback outranks a write landing on the same edge.
        if (bus.busy_set && !is_hardwired(bus.busy_addr)) begin
            busy_d[bus.busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    assign bus.dbg_data = is_hardwired(bus.dbg_addr) ? '0 : mem_q[bus.dbg_addr];

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .clk         (clk),
            .rst         (rst),
            .rd_en       (bus.rd_en[k]),
            .rd_addr     (addr),
            .stored_data (mem_q[addr]),
            .stored_busy (busy_q[addr]),
            .wa_en       (bus.wa_en),
            .wa_addr     (bus.wa_addr),
            .wa_data     (bus.wa_data),
            .wb_en       (bus.wb_en),
            .wb_addr     (bus.wb_addr),
            .wb_data     (bus.wb_data),
            .busy_set    (bus.busy_set),
            .busy_addr   (bus.busy_addr),
            .rd_data     (data),
            .rd_busy     (busy)
        );

        assign bus.rd_data[k*DATA_W +: DATA_W] = data;
        assign bus.rd_busy[k]                  = busy;
    end

endmodule
